// File: rtl/sequence_gen.sv
// Serial pattern transmitter: sends an N-bit pattern MSB first, reps times back-to-back, then
// pulses done. Optional continuous looping is compiled in with `define SEQ_LOOP_EN.
module sequence_gen #(
  parameter int unsigned N  = 4,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  pattern,
  input  logic [RW-1:0] reps,
`ifdef SEQ_LOOP_EN
  input  logic          loop,
`endif
  output logic          w,
  output logic          valid,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastBit = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e        state_q;
  logic [N-1:0]  pat_q;
  logic [N-1:0]  shreg_q;
  logic [RW-1:0] reps_q;
  logic [RW-1:0] repcnt_q;
  logic [CW-1:0] bitcnt_q;
  logic          again;

`ifdef SEQ_LOOP_EN
  assign again = loop;
`else
  assign again = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      shreg_q  <= '0;
      reps_q   <= '0;
      repcnt_q <= '0;
      bitcnt_q <= '0;
      w        <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            busy   <= 1'b1;
            pat_q  <= pattern;
            reps_q <= reps;
            if (reps != '0) begin
              state_q  <= StSend;
              shreg_q  <= pattern;
              repcnt_q <= reps;
              bitcnt_q <= '0;
              w        <= pattern[N-1];
              valid    <= 1'b1;
            end else begin
              // Zero passes requested: acknowledge with a bare done pulse.
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StSend: begin
          if (bitcnt_q != LastBit) begin
            shreg_q  <= shreg_q << 1;
            w        <= shreg_q[N-2];
            bitcnt_q <= bitcnt_q + CW'(1);
          end else if (repcnt_q > RW'(1) || again) begin
            // Next pass starts on the very next cycle; loop reloads the full rep count.
            shreg_q  <= pat_q;
            w        <= pat_q[N-1];
            bitcnt_q <= '0;
            repcnt_q <= (repcnt_q > RW'(1)) ? repcnt_q - RW'(1) : reps_q;
          end else begin
            state_q <= StDone;
            w       <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_gen.sv
// Self-checking bench for sequence_gen (N=4, RW=4): directed table, hand-written corner
// sequences and randomized traffic checked against a queue-based stream model.
module tb_sequence_gen;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 4;

  typedef struct packed {
    logic w;
    logic valid;
    logic busy;
    logic done;
  } out_t;

  typedef struct {
    logic         rst;
    logic         start;
    logic [N-1:0] pattern;
    logic [RW-1:0] reps;
    out_t         exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  pattern;
  logic [RW-1:0] reps;
  logic          w, valid, busy, done;
`ifdef SEQ_LOOP_EN
  logic          loop = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  out_t cur    = '0;
  out_t q[$];

  sequence_gen #(.N(N), .RW(RW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
`ifdef SEQ_LOOP_EN
    .loop    (loop),
`endif
    .w       (w),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input out_t exp);
    out_t got;
    got = '{w: w, valid: valid, busy: busy, done: done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got w/valid/busy/done=%b required %b", tag, cyc, got, exp);
    end
  endtask

  // mode 0: check against model; 1: model and table; 2: table only
  task automatic step(input logic r, input logic s, input logic [N-1:0] p,
                      input logic [RW-1:0] n, input int mode, input out_t tab,
                      input string tag);
    out_t e;
    @(negedge clk);
    rst = r; start = s; pattern = p; reps = n;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      cur = '0;
    end else begin
      // A request is accepted only when the previous cycle showed the link idle.
      if (!cur.busy && s) begin
        for (int k = 0; k < int'(n); k++) begin
          for (int b = N - 1; b >= 0; b--) begin
            e = '{w: p[b], valid: 1'b1, busy: 1'b1, done: 1'b0};
            q.push_back(e);
          end
        end
        e = '{w: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1};
        q.push_back(e);
      end
      cur = (q.size() != 0) ? q.pop_front() : out_t'('0);
    end
    #1;
    if (mode != 2) compare({tag, "/model"}, cur);
    if (mode != 0) compare({tag, "/table"}, tab);
  endtask

  task automatic idle(input int k, input string tag);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, '0, '0, 0, '0, tag);
  endtask

  vec_t tab[8];

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0;

    // pattern 1010 reps 1, then a reps==0 request
    tab[0] = '{1'b0, 1'b1, 4'b1010, 4'd1, 4'b1110};
    tab[1] = '{1'b0, 1'b0, 4'b0000, 4'd0, 4'b0110};
    tab[2] = '{1'b0, 1'b0, 4'b0000, 4'd0, 4'b1110};
    tab[3] = '{1'b0, 1'b0, 4'b0000, 4'd0, 4'b0110};
    tab[4] = '{1'b0, 1'b0, 4'b0000, 4'd0, 4'b0011};
    tab[5] = '{1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000};
    tab[6] = '{1'b0, 1'b1, 4'b1111, 4'd0, 4'b0011};
    tab[7] = '{1'b0, 1'b0, 4'b0000, 4'd0, 4'b0000};

    step(1'b1, 1'b0, '0, '0, 1, '0, "reset");
    step(1'b1, 1'b1, 4'b1111, 4'd3, 1, '0, "reset_with_start");
    idle(1, "post_reset_idle");

    for (int i = 0; i < 8; i++)
      step(tab[i].rst, tab[i].start, tab[i].pattern, tab[i].reps, 1, tab[i].exp, "table");

    // 12 contiguous bits 110111011101, done in cycle 13
    step(1'b0, 1'b1, 4'b1101, 4'd3, 0, '0, "reps3_start");
    idle(14, "reps3");

    // restart attempts mid-transfer are ignored
    step(1'b0, 1'b1, 4'b1001, 4'd2, 0, '0, "busy_start");
    step(1'b0, 1'b0, 4'b0000, 4'd0, 0, '0, "busy_c2");
    step(1'b0, 1'b1, 4'b1111, 4'd5, 0, '0, "busy_ignored");
    step(1'b0, 1'b1, 4'b0110, 4'd7, 0, '0, "busy_ignored");
    idle(8, "busy_tail");

    // reset aborts a transfer, then a fresh start begins at the MSB
    step(1'b0, 1'b1, 4'b1011, 4'd2, 0, '0, "abort_start");
    idle(2, "abort_run");
    step(1'b1, 1'b0, '0, '0, 1, '0, "abort_reset");
    step(1'b0, 1'b1, 4'b1100, 4'd1, 1, 4'b1110, "abort_restart_msb");
    idle(6, "abort_restart");

    // back-to-back: restart on the first idle cycle after done
    step(1'b0, 1'b1, 4'b0101, 4'd1, 0, '0, "b2b_first");
    idle(5, "b2b_run");
    step(1'b0, 1'b1, 4'b1000, 4'd2, 0, '0, "b2b_second");
    idle(10, "b2b_tail");

    // max reps
    step(1'b0, 1'b1, 4'b0111, 4'd15, 0, '0, "max_reps");
    idle(62, "max_reps_run");

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           N'($urandom), RW'($urandom_range(0, 3)), 0, '0, "random");
    idle(20, "drain");

`ifdef SEQ_LOOP_EN
    begin
      out_t e;
      logic [N-1:0] lp;
      lp = 4'b0110;
      step(1'b1, 1'b0, '0, '0, 1, '0, "loop_reset");
      for (int c = 1; c <= 15; c++) begin
        loop = (c <= 10);
        e.valid = (c <= 12);
        e.w     = e.valid ? lp[3 - ((c - 1) % 4)] : 1'b0;
        e.busy  = (c <= 13);
        e.done  = (c == 13);
        step(1'b0, (c == 1), lp, 4'd1, 2, e, "loop");
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
